// File: rtl/lpc_record_sequencer.sv
// Buffers decoded LPC cycle records and serialises each one as a 10-byte frame on a byte stream.
// Optional LPC_SEQ_OVERFLOW_MARK_EN: flag the first record popped after any drop (byte0 bit 3).
module lpc_record_sequencer #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  lpc_clock,
    input  logic                  lpc_reset,
    input  logic                  in_valid,
    input  logic [3:0]            in_cyctype_dir,
    input  logic [31:0]           in_addr,
    input  logic [31:0]           in_data,
    input  logic [2:0]            in_data_size,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [15:0]           drop_count,
    output logic                  busy
);

    // state | meaning
    // IDLE  | serialiser empty, waiting for a buffered record
    // SEND  | presenting frame bytes 0..9, byte index in idx
    typedef enum logic {IDLE, SEND} state_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [70:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [79:0]           shreg;
    logic [3:0]            idx;
    state_t                state;

    logic        full, push, drop, last_byte, pop, ovf_bit;
    logic [70:0] head;
    logic [79:0] frame;

    assign full      = (fifo_level == FULL_LVL);
    assign push      = in_valid && !full;
    assign drop      = in_valid && full;
    assign last_byte = (state == SEND) && tx_ready && (idx == 4'd9);
    assign pop       = (fifo_level != '0) && ((state == IDLE) || last_byte);
    assign head      = mem[rd_ptr];
    assign frame     = {head[70:67], ovf_bit, head[66:64], head[63:0], 8'h0A};
    assign tx_data   = shreg[79:72];

`ifdef LPC_SEQ_OVERFLOW_MARK_EN
    logic ovf_flag;
    assign ovf_bit = ovf_flag;

    // A drop coinciding with the pop re-arms the flag for the following record.
    always_ff @(posedge lpc_clock) begin
        if (!lpc_reset)
            ovf_flag <= 1'b0;
        else if (drop)
            ovf_flag <= 1'b1;
        else if (pop)
            ovf_flag <= 1'b0;
    end
`else
    assign ovf_bit = 1'b0;
`endif

    always_ff @(posedge lpc_clock) begin
        if (push)
            mem[wr_ptr] <= {in_cyctype_dir, in_data_size, in_addr, in_data};
    end

    always_ff @(posedge lpc_clock) begin
        if (!lpc_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_level <= fifo_level + 1'b1;
            else if (pop && !push)
                fifo_level <= fifo_level - 1'b1;
            if (drop && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge lpc_clock) begin
        if (!lpc_reset) begin
            state    <= IDLE;
            shreg    <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg    <= frame;
                        idx      <= '0;
                        state    <= SEND;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (idx == 4'd9) begin
                            if (pop) begin
                                shreg <= frame;
                                idx   <= '0;
                            end else begin
                                shreg    <= shreg << 8;
                                state    <= IDLE;
                                tx_valid <= 1'b0;
                                busy     <= 1'b0;
                            end
                        end else begin
                            shreg <= shreg << 8;
                            idx   <= idx + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_record_sequencer.sv
// Directed bench for lpc_record_sequencer: framing, stalls, overflow, back-to-back and reset.
module tb_lpc_record_sequencer;

    typedef struct packed {
        logic [3:0]  ct;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
    } rec_t;

`ifdef LPC_SEQ_OVERFLOW_MARK_EN
    localparam bit MARK = 1'b1;
`else
    localparam bit MARK = 1'b0;
`endif

    logic        lpc_clock = 1'b0;
    logic        lpc_reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_cyctype_dir = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic [2:0]  in_data_size = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [2:0]  fifo_level;
    logic [15:0] drop_count;
    logic        busy;

    int total = 0;
    int bad = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int bubbles;

    lpc_record_sequencer #(.DEPTH_LOG2(2)) dut (
        .lpc_clock(lpc_clock), .lpc_reset(lpc_reset), .in_valid(in_valid),
        .in_cyctype_dir(in_cyctype_dir), .in_addr(in_addr), .in_data(in_data),
        .in_data_size(in_data_size), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .fifo_level(fifo_level), .drop_count(drop_count), .busy(busy)
    );

    always #5 lpc_clock = ~lpc_clock;

    function automatic rec_t mk_rec(input int i);
        rec_t r;
        r.ct = 4'h4;
        r.sz = 3'h3;
        r.a  = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        r.d  = 32'hCAFE_0000 + 32'(i);
        return r;
    endfunction

    task automatic step();
        @(posedge lpc_clock);
        #1;
    endtask

    task automatic do_reset();
        lpc_reset = 1'b0;
        step();
        step();
        lpc_reset = 1'b1;
    endtask

    task automatic push(input rec_t r);
        in_valid = 1'b1;
        in_cyctype_dir = r.ct;
        in_data_size = r.sz;
        in_addr = r.a;
        in_data = r.d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic add_frame(input rec_t r, input bit ovf);
        exp_q.push_back({r.ct, ovf, r.sz});
        exp_q.push_back(r.a[31:24]); exp_q.push_back(r.a[23:16]);
        exp_q.push_back(r.a[15:8]);  exp_q.push_back(r.a[7:0]);
        exp_q.push_back(r.d[31:24]); exp_q.push_back(r.d[23:16]);
        exp_q.push_back(r.d[15:8]);  exp_q.push_back(r.d[7:0]);
        exp_q.push_back(8'h0A);
    endtask

    // Collect n transfers; toggle alternates tx_ready 1,0,1,0; checks stall stability.
    task automatic collect(input int n, input bit toggle, input int budget, input string name);
        logic       held_v;
        logic [7:0] held_d;
        held_v = 1'b0;
        held_d = '0;
        got.delete();
        bubbles = 0;
        for (int c = 0; c < budget && got.size() < n; c++) begin
            tx_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (held_v && tx_valid) begin
                total++;
                if (tx_data !== held_d) begin
                    bad++;
                    $display("FAIL %s_stall_stable: got %h want %h", name, tx_data, held_d);
                end
            end
            held_v = 1'b0;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            else if (tx_valid) begin
                held_v = 1'b1;
                held_d = tx_data;
            end else if (got.size() > 0 && tx_ready) bubbles++;
            step();
        end
        tx_ready = 1'b1;
        total++;
        if (got.size() != n) begin
            bad++;
            $display("FAIL %s_count: got %0d transfers want %0d (budget expired?)", name, got.size(), n);
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s_byte%0d: got %h want %h", name, i, got[i], exp_q[i]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        rec_t r;
        r = '{4'h4, 3'h2, 32'haffe7fe5, 32'h0000df6c};
        tx_ready = 1'b1;
        push(r);
        total++; if (tx_valid !== 1'b0 || fifo_level !== 3'd1) begin
            bad++; $display("FAIL single_pre: got valid=%b level=%0d want valid=0 level=1", tx_valid, fifo_level);
        end
        step();
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h42 || busy !== 1'b1) begin
            bad++; $display("FAIL single_latency: got valid=%b data=%h busy=%b want 1/42/1", tx_valid, tx_data, busy);
        end
        add_frame(r, 1'b0);
        collect(10, 1'b0, 40, "single");
        total++; if (bubbles != 0) begin bad++; $display("FAIL single_bubbles: got %0d want 0", bubbles); end
        total++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            bad++; $display("FAIL single_idle: got busy=%b valid=%b want 0/0", busy, tx_valid);
        end
    endtask

    task automatic test_toggle();
        rec_t r;
        r = '{4'h4, 3'h2, 32'haffe7fe5, 32'h0000df6c};
        tx_ready = 1'b0;
        push(r);
        step();
        add_frame(r, 1'b0);
        collect(10, 1'b1, 60, "toggle");
        step();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL toggle_extra: got valid=%b want 0", tx_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(mk_rec(i));
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
        total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL ovf_drop: got %0d want 1", drop_count); end
        total++; if (busy !== 1'b1 || tx_data !== 8'h43) begin
            bad++; $display("FAIL ovf_head: got busy=%b data=%h want 1/43", busy, tx_data);
        end
        add_frame(mk_rec(1), 1'b0);
        add_frame(mk_rec(2), MARK);
        for (int i = 3; i <= 5; i++) add_frame(mk_rec(i), 1'b0);
        collect(50, 1'b0, 200, "ovf");
        total++; if (bubbles != 0) begin bad++; $display("FAIL ovf_bubbles: got %0d want 0", bubbles); end
        step(); step();
        total++; if (tx_valid !== 1'b0 || fifo_level !== 3'd0) begin
            bad++; $display("FAIL ovf_sixth: got valid=%b level=%0d want 0/0", tx_valid, fifo_level);
        end
        push(mk_rec(7));
        step();
        add_frame(mk_rec(7), 1'b0);
        collect(10, 1'b0, 40, "ovf_after");
    endtask

    task automatic test_full_pop();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(mk_rec(i));
        total++; if (fifo_level !== 3'd4 || drop_count !== 16'd0) begin
            bad++; $display("FAIL fullpop_pre: got level=%0d drop=%0d want 4/0", fifo_level, drop_count);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 9; i++) step();
        total++; if (tx_data !== 8'h0A) begin bad++; $display("FAIL fullpop_term: got %h want 0a", tx_data); end
        push(mk_rec(9));
        total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL fullpop_drop: got %0d want 1", drop_count); end
        total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL fullpop_level: got %0d want 3", fifo_level); end
        add_frame(mk_rec(2), 1'b0);
        add_frame(mk_rec(3), MARK);
        add_frame(mk_rec(4), 1'b0);
        collect(30, 1'b0, 120, "fullpop");
    endtask

    task automatic test_reset_mid();
        rec_t r;
        do_reset();
        tx_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(mk_rec(i));
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        total++; if (tx_data !== mk_rec(1).a[7:0]) begin
            bad++; $display("FAIL mid_byte4: got %h want %h", tx_data, mk_rec(1).a[7:0]);
        end
        lpc_reset = 1'b0;
        step();
        lpc_reset = 1'b1;
        total++; if (tx_valid !== 1'b0 || fifo_level !== 3'd0 || drop_count !== 16'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_reset: got valid=%b level=%0d drop=%0d busy=%b want 0/0/0/0",
                            tx_valid, fifo_level, drop_count, busy);
        end
        step(); step();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_quiet: got valid=%b want 0", tx_valid); end
        r = '{4'h4, 3'h2, 32'haffe7fe5, 32'h0000df6c};
        push(r);
        step();
        add_frame(r, 1'b0);
        collect(10, 1'b0, 40, "mid_fresh");
    endtask

    initial begin
        test_reset();
        test_single();
        test_toggle();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
